// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state for the trailing checksum.
package imem_loader_pkg;

    localparam int DEFAULT_MEM_DEPTH = 16384;
    localparam int BYTES_PER_WORD    = 4;
    localparam int WORD_BITS         = 32;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_DONE,
        ST_ERROR
    } state_e;

    // Counters must reach MEM_DEPTH itself, hence depth+1.
    function automatic int idx_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [31:0] word_addr(
        input logic [31:0] base,
        input logic [31:0] idx
    );
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word assembler; a word pops out when byte 3
// or a last-flagged byte arrives, with unfilled upper bytes zero.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [23:0] buf_q, buf_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] merged;
    logic        complete;

    always_comb begin
        merged = {8'h00, buf_q};
        merged[8*cnt_q +: 8] = byte_data;
    end

    assign complete   = byte_valid && ((cnt_q == 2'd3) || byte_last);
    assign word_valid = complete;
    assign word_data  = merged;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (complete) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (byte_valid) begin
            buf_d = merged[23:0];
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: zero-fills instruction memory, streams in a program, releases
// the core. IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit sum check.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int IW = idx_width(MEM_DEPTH);
    localparam logic [IW-1:0] DEPTH_N = IW'(MEM_DEPTH);

    state_e        state_q, state_d;
    logic [IW-1:0] clr_q, clr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          fin_q, fin_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          in_ready_q, in_ready_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   sum_q, sum_d;
`endif

    logic        accept;
    logic        full;
    logic        in_check;
    logic        pk_in_valid;
    logic        pk_in_last;
    logic        pk_valid;
    logic [31:0] pk_word;

    assign accept = in_valid && in_ready_q;
    assign full   = (idx_q == DEPTH_N);

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign in_check = (state_q == ST_CHECK);
`else
    assign in_check = 1'b0;
`endif

    // A byte that would overflow memory never reaches the packer.
    assign pk_in_valid = accept &&
        (in_check || ((state_q == ST_LOAD) && !full));
    assign pk_in_last  = in_last && (state_q == ST_LOAD);

    imem_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (pk_in_valid),
        .byte_data  (in_data),
        .byte_last  (pk_in_last),
        .word_valid (pk_valid),
        .word_data  (pk_word)
    );

    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        idx_d       = idx_q;
        fin_d       = fin_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = '0;
        in_ready_d  = in_ready_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            ST_CLEAR: begin
                if (clr_q != DEPTH_N) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = word_addr(BASE_ADDR, 32'(clr_q));
                    clr_d      = clr_q + 1'b1;
                end else begin
                    state_d    = ST_LOAD;
                    in_ready_d = 1'b1;
                    mem_addr_d = BASE_ADDR;
                end
            end
            ST_LOAD: begin
                if (fin_q) begin
                    // Final word write is on the bus this cycle.
                    fin_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d    = ST_CHECK;
                    in_ready_d = 1'b1;
`else
                    state_d    = ST_DONE;
                    in_ready_d = 1'b0;
`endif
                end else if (accept && full) begin
                    state_d    = ST_ERROR;
                    in_ready_d = 1'b0;
                end else if (pk_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_addr(BASE_ADDR, 32'(idx_q));
                    mem_wdata_d = pk_word;
                    idx_d       = idx_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + pk_word;
`endif
                    if (in_last) begin
                        fin_d      = 1'b1;
                        in_ready_d = 1'b0;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (pk_valid) begin
                    in_ready_d = 1'b0;
                    state_d    = (pk_word == sum_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            ST_DONE: begin
                in_ready_d = 1'b0;
            end
            ST_ERROR: begin
                in_ready_d = 1'b0;
            end
            default: begin
                state_d    = ST_ERROR;
                in_ready_d = 1'b0;
            end
        endcase

        cpu_hold_d = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clr_q       <= '0;
            idx_q       <= '0;
            fin_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            in_ready_q  <= 1'b0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            idx_q       <= idx_d;
            fin_q       <= fin_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            in_ready_q  <= in_ready_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: depth-8 instance for load scenarios,
// depth-2 instance at base 0x100 for overflow.
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        reset, in_valid, in_last;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, cpu_hold, done, error;
    logic [31:0] mem_addr, mem_wdata;

    logic        reset_b, in_valid_b, in_last_b;
    logic [7:0]  in_data_b;
    logic        in_ready_b, mem_we_b, cpu_hold_b, done_b, error_b;
    logic [31:0] mem_addr_b, mem_wdata_b;

    imem_loader #(.MEM_DEPTH(8), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error)
    );

    imem_loader #(.MEM_DEPTH(2), .BASE_ADDR(32'h100)) dut_b (
        .clk(clk), .reset(reset_b),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_last(in_last_b),
        .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .cpu_hold(cpu_hold_b),
        .done(done_b), .error(error_b)
    );

    logic [31:0] wa[$], wd[$], wa_b[$], wd_b[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
        if (mem_we_b === 1'b1) begin
            wa_b.push_back(mem_addr_b);
            wd_b.push_back(mem_wdata_b);
        end
    end

    task automatic clear_log();
        wa.delete(); wd.delete();
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout: in_ready=%b required 1", tag, in_ready);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic l, input logic no_bubble);
        if (no_bubble) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL bubble: in_ready=%b required 1 for byte %h", in_ready, b);
            end
        end
        wait_ready("send");
        in_valid = 1'b1; in_data = b; in_last = l;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_sum(input logic [31:0] s);
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int k = 0; k < 4; k++) send(s[8*k +: 8], 1'b0, 1'b0);
`else
        in_data = s[7:0];
`endif
    endtask

    task automatic wait_end();
        int n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_dut();
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_ready("reset_dut");
    endtask

    task automatic test_reset();
        int n = 0;
        logic hold_ok = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_we, in_ready, cpu_hold, done, error} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_flags: we,rdy,hold,done,err=%b required 00100",
                {mem_we, in_ready, cpu_hold, done, error});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h required 0 0", mem_addr, mem_wdata);
        end
        reset = 1'b0;
        clear_log();
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            if (cpu_hold !== 1'b1) hold_ok = 1'b0;
            n++;
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL clear_hold: cpu_hold dropped required 1");
        end
        checks++;
        if (wa.size() != 8) begin
            errors++;
            $display("FAIL clear_count: writes=%0d required 8", wa.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < wa.size()) begin
                checks++;
                if (wa[i] !== 32'(i * 4) || wd[i] !== 32'h0) begin
                    errors++;
                    $display("FAIL clear_write%0d: %h@%h required 0@%h",
                        i, wd[i], wa[i], i * 4);
                end
            end
        end
    endtask

    task automatic test_load_two();
        clear_log();
        send(8'h13, 1'b0, 1'b1); send(8'h00, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b1); send(8'h00, 1'b0, 1'b1);
        send(8'h6F, 1'b0, 1'b1); send(8'h00, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b1); send(8'h00, 1'b1, 1'b1);
        send_sum(32'h0000_0082);
        wait_end();
        checks++;
        if (wa.size() != 2) begin
            errors++;
            $display("FAIL load_count: writes=%0d required 2", wa.size());
        end else begin
            checks++;
            if (wa[0] !== 32'h0 || wd[0] !== 32'h13) begin
                errors++;
                $display("FAIL load_w0: %h@%h required 00000013@0", wd[0], wa[0]);
            end
            checks++;
            if (wa[1] !== 32'h4 || wd[1] !== 32'h6F) begin
                errors++;
                $display("FAIL load_w1: %h@%h required 0000006f@4", wd[1], wa[1]);
            end
        end
        checks++;
        if ({done, cpu_hold, error, in_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL load_status: done,hold,err,rdy=%b required 1000",
                {done, cpu_hold, error, in_ready});
        end
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (wa.size() != 2 || done !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL done_ignore: writes=%0d done=%b hold=%b required 2 1 0",
                wa.size(), done, cpu_hold);
        end
    endtask

    task automatic test_partial();
        reset_dut();
        clear_log();
        send(8'hAA, 1'b0, 1'b1);
        send(8'hBB, 1'b1, 1'b1);
        send_sum(32'h0000_BBAA);
        wait_end();
        checks++;
        if (wa.size() != 1) begin
            errors++;
            $display("FAIL partial_count: writes=%0d required 1", wa.size());
        end else begin
            checks++;
            if (wa[0] !== 32'h0 || wd[0] !== 32'h0000_BBAA) begin
                errors++;
                $display("FAIL partial_word: %h@%h required 0000bbaa@0", wd[0], wa[0]);
            end
        end
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL partial_done: done=%b hold=%b required 1 0", done, cpu_hold);
        end
    endtask

    task automatic test_reset_midload();
        reset_dut();
        for (int i = 0; i < 6; i++) send(8'(8'h11 + i), 1'b0, 1'b1);
        reset_dut();
        clear_log();
        send(8'h01, 1'b0, 1'b1); send(8'h02, 1'b0, 1'b1);
        send(8'h03, 1'b0, 1'b1); send(8'h04, 1'b1, 1'b1);
        send_sum(32'h0403_0201);
        wait_end();
        checks++;
        if (wa.size() != 1) begin
            errors++;
            $display("FAIL midload_count: writes=%0d required 1", wa.size());
        end else begin
            checks++;
            if (wa[0] !== 32'h0 || wd[0] !== 32'h0403_0201) begin
                errors++;
                $display("FAIL midload_word: %h@%h required 04030201@0", wd[0], wa[0]);
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL midload_done: done=%b required 1", done);
        end
    endtask

    task automatic test_reset_midclear();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        wait_ready("midclear");
        checks++;
        if (wa.size() != 8 || (wa.size() == 8 && wa[7] !== 32'h1C)) begin
            errors++;
            $display("FAIL midclear_count: writes=%0d required 8 ending at 1c", wa.size());
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        reset_b = 1'b1; in_valid_b = 1'b0; in_last_b = 1'b0; in_data_b = '0;
        @(negedge clk);
        reset_b = 1'b0;
        wa_b.delete(); wd_b.delete();
        while (in_ready_b !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wa_b.size() != 2 || (wa_b.size() == 2 && wa_b[1] !== 32'h104)) begin
            errors++;
            $display("FAIL ovf_clear: writes=%0d required 2 ending at 104", wa_b.size());
        end
        wa_b.delete(); wd_b.delete();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (in_ready_b !== 1'b1) begin
                errors++;
                $display("FAIL ovf_ready%0d: in_ready=%b required 1", i, in_ready_b);
            end
            in_valid_b = 1'b1; in_data_b = 8'(i + 1);
            @(negedge clk);
        end
        in_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wa_b.size() != 2) begin
            errors++;
            $display("FAIL ovf_count: writes=%0d required 2", wa_b.size());
        end else begin
            checks++;
            if (wa_b[0] !== 32'h100 || wd_b[0] !== 32'h0403_0201 ||
                wa_b[1] !== 32'h104 || wd_b[1] !== 32'h0807_0605) begin
                errors++;
                $display("FAIL ovf_words: %h@%h %h@%h required 04030201@100 08070605@104",
                    wd_b[0], wa_b[0], wd_b[1], wa_b[1]);
            end
        end
        checks++;
        if ({error_b, cpu_hold_b, done_b, in_ready_b} !== 4'b1100) begin
            errors++;
            $display("FAIL ovf_status: err,hold,done,rdy=%b required 1100",
                {error_b, cpu_hold_b, done_b, in_ready_b});
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        reset_dut();
        send(8'h13, 1'b0, 1'b1); send(8'h00, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b1); send(8'h00, 1'b1, 1'b1);
        send_sum(32'h0000_0013);
        wait_end();
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL sum_match: done=%b err=%b hold=%b required 1 0 0",
                done, error, cpu_hold);
        end
        reset_dut();
        send(8'h13, 1'b0, 1'b1); send(8'h00, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b1); send(8'h00, 1'b1, 1'b1);
        send_sum(32'h0000_0014);
        wait_end();
        checks++;
        if (done !== 1'b0 || error !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL sum_mismatch: done=%b err=%b hold=%b required 0 1 1",
                done, error, cpu_hold);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        reset_b = 1'b1; in_valid_b = 1'b0; in_last_b = 1'b0; in_data_b = '0;
        test_reset();
        test_load_two();
        test_partial();
        test_reset_midload();
        test_reset_midclear();
        test_overflow();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
